// File: rtl/turbo_pkg.sv
// Shared turbo-decoder definitions: sample width, lane count, default QPP
// frame parameters, the ping-pong bank state and an elaboration-time QPP helper.
package turbo_pkg;

    localparam int unsigned W      = 30;
    localparam int unsigned LANES  = 4;
    localparam int unsigned N_DEF  = 40;
    localparam int unsigned F1_DEF = 3;
    localparam int unsigned F2_DEF = 10;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Constant-only QPP value used to seed the address recursion.
    function automatic int unsigned qpp_pi(input int unsigned i, input int unsigned n,
                                           input int unsigned f1, input int unsigned f2);
        return (f1 * i + f2 * i * i) % n;
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// QPP address generator: presents pi(4j+k) for lanes k=0..3 of the current
// output word j, advancing by four samples per step with mod-N adders only.
// Ports: clk, rst (async active-low), start (reload word 0), step (advance),
//        o_addr (lane addresses of the current word).
module qpp_addr_gen
    import turbo_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned F1 = F1_DEF,
    parameter int unsigned F2 = F2_DEF,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      step,
    output logic [LANES-1:0][AW-1:0]  o_addr
);

    // pi(i+4) - pi(i) = 4*F1 + 16*F2 + 8*F2*i, which itself grows by 32*F2 per step.
    localparam int unsigned D_INC = (32 * F2) % N;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned P_SEED = qpp_pi(k, N, F1, F2);
        localparam int unsigned D_SEED = (4 * F1 + 16 * F2 + 8 * F2 * k) % N;

        logic [AW-1:0] r_p;
        logic [AW-1:0] r_d;
        logic [AW:0]   w_p_sum;
        logic [AW:0]   w_d_sum;
        logic [AW-1:0] w_p_nxt;
        logic [AW-1:0] w_d_nxt;

        // Both operands stay below N, so one conditional subtract reduces the sum.
        always_comb begin
            w_p_sum = {1'b0, r_p} + {1'b0, r_d};
            w_d_sum = {1'b0, r_d} + (AW+1)'(D_INC);
            w_p_nxt = (w_p_sum >= (AW+1)'(N)) ? AW'(w_p_sum - (AW+1)'(N)) : AW'(w_p_sum);
            w_d_nxt = (w_d_sum >= (AW+1)'(N)) ? AW'(w_d_sum - (AW+1)'(N)) : AW'(w_d_sum);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_p <= AW'(P_SEED);
                r_d <= AW'(D_SEED);
            end else if (start) begin
                r_p <= AW'(P_SEED);
                r_d <= AW'(D_SEED);
            end else if (step) begin
                r_p <= w_p_nxt;
                r_d <= w_d_nxt;
            end
        end

        assign o_addr[k] = r_p;
    end

endmodule

// File: rtl/extrinsic_interleaver.sv
// Ping-pong QPP interleaver: writes four-lane extrinsic words in natural
// order into one bank while the other bank is read out in QPP order.
// Ports: clk, rst (async active-low); in_valid/in_ready/w_in0..3 (natural-order
//        input words); out_valid/out_ready/z_out0..3/out_last (interleaved output).
module extrinsic_interleaver
    import turbo_pkg::*;
#(
    parameter int unsigned W  = turbo_pkg::W,
    parameter int unsigned N  = N_DEF,
    parameter int unsigned F1 = F1_DEF,
    parameter int unsigned F2 = F2_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] w_in0,
    input  logic [W-1:0] w_in1,
    input  logic [W-1:0] w_in2,
    input  logic [W-1:0] w_in3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z_out0,
    output logic [W-1:0] z_out1,
    output logic [W-1:0] z_out2,
    output logic [W-1:0] z_out3,
    output logic         out_last
);

    localparam int unsigned NW = N / LANES;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

    bank_state_e                  r_state [2];
    bank_state_e                  w_state_nxt [2];
    logic                         r_wr_bank;
    logic                         r_rd_bank;
    logic [CW-1:0]                r_wr_cnt;
    logic [CW-1:0]                r_rd_cnt;
    logic [W-1:0]                 r_mem [2][N];
    logic                         r_out_valid;
    logic                         r_out_last;
    logic [LANES-1:0][W-1:0]      r_z;

    logic                         w_wr;
    logic                         w_wr_last;
    logic                         w_rd_last;
    logic                         w_rd_avail;
    logic                         w_fetch;
    logic [LANES-1:0][W-1:0]      w_in_lanes;
    logic [LANES-1:0][W-1:0]      w_rd_data;
    logic [LANES-1:0][AW-1:0]     w_addr;
    logic [AW-1:0]                w_wr_base;

    // Handshake and fetch qualification.
    always_comb begin
        in_ready   = (r_state[r_wr_bank] == BANK_EMPTY) || (r_state[r_wr_bank] == BANK_FILLING);
        w_wr       = in_valid && in_ready;
        w_wr_last  = (r_wr_cnt == CW'(NW - 1));
        w_rd_last  = (r_rd_cnt == CW'(NW - 1));
        w_rd_avail = (r_state[r_rd_bank] == BANK_FULL) || (r_state[r_rd_bank] == BANK_DRAINING);
        w_fetch    = w_rd_avail && (!r_out_valid || out_ready);
        w_in_lanes = {w_in3, w_in2, w_in1, w_in0};
        w_wr_base  = AW'({r_wr_cnt, 2'b00});
    end

    // Bank state next-state; a bank is never written and fetched in the same cycle
    // because the two events require disjoint states.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_wr && (r_wr_bank == 1'(b))) begin
                w_state_nxt[b] = w_wr_last ? BANK_FULL : BANK_FILLING;
            end
            if (w_fetch && (r_rd_bank == 1'(b))) begin
                w_state_nxt[b] = w_rd_last ? BANK_EMPTY : BANK_DRAINING;
            end
        end
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    // Write/read word counters and bank pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_bank <= 1'b0;
            r_rd_cnt  <= '0;
        end else begin
            if (w_wr) begin
                if (w_wr_last) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + CW'(1);
                end
            end
            if (w_fetch) begin
                if (w_rd_last) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_cnt <= r_rd_cnt + CW'(1);
                end
            end
        end
    end

    // Sample storage; contents are don't-care until the bank state says otherwise.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int k = 0; k < LANES; k++) begin
                r_mem[r_wr_bank][w_wr_base + AW'(k)] <= w_in_lanes[k];
            end
        end
    end

    qpp_addr_gen #(
        .N  (N),
        .F1 (F1),
        .F2 (F2)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .start  (w_fetch && w_rd_last),
        .step   (w_fetch),
        .o_addr (w_addr)
    );

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_rd_data[k] = r_mem[r_rd_bank][w_addr[k]];
        end
    end

    // Output register: loads on fetch, holds under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_z         <= '0;
        end else if (w_fetch) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_rd_last;
            r_z         <= w_rd_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign z_out0    = r_z[0];
    assign z_out1    = r_z[1];
    assign z_out2    = r_z[2];
    assign z_out3    = r_z[3];

endmodule

// File: tb/tb_extrinsic_interleaver.sv
`timescale 1ns/1ps
module tb_extrinsic_interleaver;

    localparam int unsigned W  = 30;
    localparam int unsigned N  = 40;
    localparam int unsigned F1 = 3;
    localparam int unsigned F2 = 10;
    localparam int unsigned NW = N / 4;

    typedef struct packed {
        logic                last;
        logic [3:0][W-1:0]   d;
    } word_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] w_in0 = '0, w_in1 = '0, w_in2 = '0, w_in3 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] z_out0, z_out1, z_out2, z_out3;
    logic         out_last;

    always #5 clk = ~clk;

    extrinsic_interleaver #(.W(W), .N(N), .F1(F1), .F2(F2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .w_in0(w_in0), .w_in1(w_in1), .w_in2(w_in2), .w_in3(w_in3),
        .out_valid(out_valid), .out_ready(out_ready),
        .z_out0(z_out0), .z_out1(z_out1), .z_out2(z_out2), .z_out3(z_out3),
        .out_last(out_last)
    );

    word_t exp_q[$];
    word_t log_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    stall_cnt = 0;
    bit    rand_en = 1'b0;

    function automatic int unsigned pi(input int unsigned i);
        return (F1 * i + F2 * i * i) % N;
    endfunction

    function automatic word_t mk(input int unsigned a, input int unsigned b,
                                 input int unsigned c, input int unsigned d, input bit l);
        word_t r;
        r.last = l;
        r.d[0] = W'(a);
        r.d[1] = W'(b);
        r.d[2] = W'(c);
        r.d[3] = W'(d);
        return r;
    endfunction

    function automatic word_t ref_word(input int unsigned base, input int unsigned j);
        word_t r;
        r.last = (j == NW - 1);
        for (int k = 0; k < 4; k++) r.d[k] = W'(base + pi(4 * j + k));
        return r;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, req, $time);
        end
    endtask

    task automatic check_word(input string name, input word_t got, input word_t req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got last=%0b {%0d,%0d,%0d,%0d} required last=%0b {%0d,%0d,%0d,%0d} (t=%0t)",
                     name, got.last, got.d[0], got.d[1], got.d[2], got.d[3],
                     req.last, req.d[0], req.d[1], req.d[2], req.d[3], $time);
        end
    endtask

    // Monitor: compares every accepted output word and checks hold under backpressure.
    word_t prev_w;
    bit    prev_stall = 1'b0;
    always @(negedge clk) begin
        word_t cur;
        word_t e;
        cur.last = out_last;
        cur.d[0] = z_out0;
        cur.d[1] = z_out1;
        cur.d[2] = z_out2;
        cur.d[3] = z_out3;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("hold_valid", 32'(out_valid), 32'd1);
                check_word("hold_data", cur, prev_w);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got {%0d,%0d,%0d,%0d} required no output",
                             cur.d[0], cur.d[1], cur.d[2], cur.d[3]);
                end else begin
                    e = exp_q.pop_front();
                    check_word("sb_word", cur, e);
                end
                log_q.push_back(cur);
            end
            prev_stall = out_valid && !out_ready;
            prev_w     = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_en) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_word(input int unsigned base, input int unsigned j);
        bit ok;
        int c;
        in_valid = 1'b1;
        w_in0 = W'(base + 4 * j);
        w_in1 = W'(base + 4 * j + 1);
        w_in2 = W'(base + 4 * j + 2);
        w_in3 = W'(base + 4 * j + 3);
        c = 0;
        forever begin
            ok = in_ready;
            tick();
            if (ok) break;
            stall_cnt++;
            c++;
            if (c > 2000) begin
                n_checks++;
                n_errors++;
                $display("FAIL in_ready_timeout: got no acceptance required acceptance within 2000 cycles");
                break;
            end
        end
    endtask

    task automatic send_frame(input int unsigned base);
        for (int j = 0; j < NW; j++) exp_q.push_back(ref_word(base, j));
        for (int j = 0; j < NW; j++) send_word(base, j);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            tick();
            c++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending words required 0", exp_q.size());
        end
    endtask

    task automatic perm_check(input int unsigned base, input int unsigned first);
        bit seen [N];
        int distinct;
        int unsigned v;
        distinct = 0;
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < 4; k++) begin
                v = 32'(log_q[first + w].d[k]) - base;
                if (v < N && !seen[v]) begin
                    seen[v] = 1'b1;
                    distinct++;
                end
            end
        end
        check_val("perm_distinct", 32'(distinct), 32'(N));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion required completion");
        $fatal(1);
    end

    initial begin
        int lasts;

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_last", 32'(out_last), 32'd0);
        check_val("rst_z", 32'(|{z_out0, z_out1, z_out2, z_out3}), 32'd0);
        tick();

        // One frame, entry i = i, out_ready high
        out_ready = 1'b1;
        log_q.delete();
        send_frame(0);
        in_valid = 1'b0;
        check_val("lat_edge_t", 32'(out_valid), 32'd0);
        tick();
        check_val("lat_edge_t1", 32'(out_valid), 32'd1);
        wait_drain();
        check_val("f1_count", 32'(log_q.size()), 32'(NW));
        if (log_q.size() == NW) begin
            check_word("f1_word0", log_q[0], mk(0, 13, 6, 19, 1'b0));
            check_word("f1_word1", log_q[1], mk(12, 25, 18, 31, 1'b0));
            check_val("f1_last9", 32'(log_q[9].last), 32'd1);
            lasts = 0;
            for (int j = 0; j < NW - 1; j++) lasts += int'(log_q[j].last);
            check_val("f1_early_last", 32'(lasts), 32'd0);
            perm_check(0, 0);
        end
        tick();

        // Back-to-back frames, in_valid continuous
        log_q.delete();
        stall_cnt = 0;
        send_frame(100);
        send_frame(200);
        in_valid = 1'b0;
        check_val("b2b_stalls", 32'(stall_cnt), 32'd0);
        wait_drain();
        if (log_q.size() >= 1) check_word("f2_word0", log_q[0], mk(100, 113, 106, 119, 1'b0));
        check_val("b2b_count", 32'(log_q.size()), 32'(2 * NW));
        tick();

        // Three frames queued with out_ready low
        log_q.delete();
        out_ready = 1'b0;
        send_frame(300);
        send_frame(400);
        check_val("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        w_in0 = W'(500); w_in1 = W'(501); w_in2 = W'(502); w_in3 = W'(503);
        for (int c = 0; c < 6; c++) begin
            tick();
            check_val("stall_in_ready", 32'(in_ready), 32'd0);
            check_val("stall_out_valid", 32'(out_valid), 32'd1);
            check_word("stall_head", word_t'({out_last, z_out3, z_out2, z_out1, z_out0}),
                       mk(300, 313, 306, 319, 1'b0));
        end
        out_ready = 1'b1;
        send_frame(500);
        in_valid = 1'b0;
        wait_drain();
        check_val("q3_count", 32'(log_q.size()), 32'(3 * NW));
        tick();

        // Random out_ready over four frames
        log_q.delete();
        rand_en = 1'b1;
        send_frame(1000);
        send_frame(2000);
        send_frame(3000);
        send_frame(4000);
        in_valid = 1'b0;
        wait_drain();
        rand_en = 1'b0;
        out_ready = 1'b1;
        check_val("rand_count", 32'(log_q.size()), 32'(4 * NW));
        tick();

        // Async reset mid-drain of one frame and mid-write of the next
        send_frame(700);
        for (int j = 0; j < 5; j++) send_word(800, j);
        #3;
        rst = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_out_last", 32'(out_last), 32'd0);
        check_val("mid_rst_z", 32'(|{z_out0, z_out1, z_out2, z_out3}), 32'd0);
        check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        log_q.delete();
        send_frame(0);
        in_valid = 1'b0;
        wait_drain();
        check_val("post_rst_count", 32'(log_q.size()), 32'(NW));
        if (log_q.size() == NW) begin
            check_word("post_rst_word0", log_q[0], mk(0, 13, 6, 19, 1'b0));
            perm_check(0, 0);
        end
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
